compression_controller: RTL and testbench

- Level-driven scheduler for the 12-bit compression datapath at 24 kHz.
- Watches the same incoming sample stream and ready strobe as the compressor.
- Computes and sequences the 2-bit compression_amount that configures the compressor, using attack/hold/release timing and a manual override from the front-panel switches.
- Sits between the audio input stage and the compression block.

---
 rtl/compression_controller.sv | 185 ++++++++++++++++++
 tb/tb_compression_controller.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/compression_controller.sv
// Attack/hold/release scheduler that sets the compressor's 2-bit amount from sample magnitude.
// Optional peak meter (peak_clear/peak_level) is built when COMP_CTRL_PEAK_METER_EN is defined.
module compression_controller #(
    parameter int unsigned SAMPLING_RATE   = 24000,
    parameter int unsigned ATTACK_SAMPLES  = SAMPLING_RATE / 1000,
    parameter int unsigned HOLD_SAMPLES    = SAMPLING_RATE / 10,
    parameter int unsigned RELEASE_SAMPLES = SAMPLING_RATE / 20,
    parameter int unsigned THRESHOLD_1     = 512,
    parameter int unsigned THRESHOLD_2     = 1024,
    parameter int unsigned THRESHOLD_3     = 1536
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ready,
    input  logic signed [11:0] incoming_sample,
    input  logic               manual_en,
    input  logic        [1:0]  manual_amount,
`ifdef COMP_CTRL_PEAK_METER_EN
    input  logic               peak_clear,
    output logic        [10:0] peak_level,
`endif
    output logic        [1:0]  compression_amount,
    output logic               amount_changed,
    output logic        [1:0]  state_out
);

    localparam int unsigned ATK_W = $clog2(ATTACK_SAMPLES + 1);
    localparam int unsigned HLD_W = $clog2(HOLD_SAMPLES + 1);
    localparam int unsigned REL_W = $clog2(RELEASE_SAMPLES + 1);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StAttack  = 2'd1;
    localparam logic [1:0] StHold    = 2'd2;
    localparam logic [1:0] StRelease = 2'd3;

    logic [1:0]       r_state, w_state_d;
    logic [1:0]       r_amt, w_amt_d;
    logic [ATK_W-1:0] r_atk_cnt, w_atk_cnt_d;
    logic [HLD_W-1:0] r_hold_cnt, w_hold_cnt_d;
    logic [REL_W-1:0] r_rel_cnt, w_rel_cnt_d;
    logic [1:0]       r_comp_amt, w_comp_amt_d;
    logic             r_changed;

    logic [10:0] w_mag;
    logic [1:0]  w_target;
    logic        w_atk_done, w_hold_done, w_rel_done;

    // -2048 has no 11-bit magnitude, so it saturates to 2047.
    always_comb begin
        if (incoming_sample == 12'sh800) begin
            w_mag = 11'h7FF;
        end else if (incoming_sample[11]) begin
            w_mag = ~incoming_sample[10:0] + 11'd1;
        end else begin
            w_mag = incoming_sample[10:0];
        end
    end

    assign w_target = {1'b0, (32'(w_mag) >= THRESHOLD_1)}
                    + {1'b0, (32'(w_mag) >= THRESHOLD_2)}
                    + {1'b0, (32'(w_mag) >= THRESHOLD_3)};

    assign w_atk_done  = (32'(r_atk_cnt) + 32'd1) >= ATTACK_SAMPLES;
    assign w_hold_done = (32'(r_hold_cnt) + 32'd1) >= HOLD_SAMPLES;
    assign w_rel_done  = (32'(r_rel_cnt) + 32'd1) >= RELEASE_SAMPLES;

    always_comb begin
        w_state_d    = r_state;
        w_amt_d      = r_amt;
        w_atk_cnt_d  = r_atk_cnt;
        w_hold_cnt_d = r_hold_cnt;
        w_rel_cnt_d  = r_rel_cnt;
        if (manual_en) begin
            w_state_d    = StIdle;
            w_amt_d      = 2'd0;
            w_atk_cnt_d  = '0;
            w_hold_cnt_d = '0;
            w_rel_cnt_d  = '0;
        end else if (ready) begin
            case (r_state)
                StIdle: begin
                    if (w_target > r_amt) begin
                        w_state_d   = StAttack;
                        w_atk_cnt_d = ATK_W'(1);
                    end
                end
                StAttack: begin
                    if (w_target > r_amt) begin
                        if (w_atk_done) begin
                            if (r_amt != 2'd3) w_amt_d = r_amt + 2'd1;
                            w_state_d    = StHold;
                            w_atk_cnt_d  = '0;
                            w_hold_cnt_d = '0;
                        end else begin
                            w_atk_cnt_d = r_atk_cnt + ATK_W'(1);
                        end
                    end else begin
                        w_state_d    = StHold;
                        w_atk_cnt_d  = '0;
                        w_hold_cnt_d = '0;
                    end
                end
                StHold: begin
                    if (w_target > r_amt) begin
                        w_state_d    = StAttack;
                        w_atk_cnt_d  = ATK_W'(1);
                        w_hold_cnt_d = '0;
                    end else if (r_amt == 2'd0) begin
                        w_state_d    = StIdle;
                        w_hold_cnt_d = '0;
                    end else if (w_target == r_amt) begin
                        w_hold_cnt_d = '0;
                    end else if (w_hold_done) begin
                        w_state_d    = StRelease;
                        w_hold_cnt_d = '0;
                        w_rel_cnt_d  = '0;
                    end else begin
                        w_hold_cnt_d = r_hold_cnt + HLD_W'(1);
                    end
                end
                default: begin
                    if (w_target > r_amt) begin
                        w_state_d   = StAttack;
                        w_atk_cnt_d = ATK_W'(1);
                        w_rel_cnt_d = '0;
                    end else if (w_target == r_amt) begin
                        w_state_d    = StHold;
                        w_hold_cnt_d = '0;
                        w_rel_cnt_d  = '0;
                    end else if (w_rel_done) begin
                        w_amt_d     = r_amt - 2'd1;
                        w_rel_cnt_d = '0;
                        if (r_amt == 2'd1) w_state_d = StIdle;
                    end else begin
                        w_rel_cnt_d = r_rel_cnt + REL_W'(1);
                    end
                end
            endcase
        end
    end

    assign w_comp_amt_d = manual_en ? manual_amount : w_amt_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_amt      <= 2'd0;
            r_atk_cnt  <= '0;
            r_hold_cnt <= '0;
            r_rel_cnt  <= '0;
            r_comp_amt <= 2'd0;
            r_changed  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_amt      <= w_amt_d;
            r_atk_cnt  <= w_atk_cnt_d;
            r_hold_cnt <= w_hold_cnt_d;
            r_rel_cnt  <= w_rel_cnt_d;
            r_comp_amt <= w_comp_amt_d;
            r_changed  <= (w_comp_amt_d != r_comp_amt);
        end
    end

    assign compression_amount = r_comp_amt;
    assign amount_changed     = r_changed;
    assign state_out          = r_state;

`ifdef COMP_CTRL_PEAK_METER_EN
    logic [10:0] r_peak;

    // A clear coinciding with a ready sample restarts the peak at that sample.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_peak <= 11'd0;
        end else if (peak_clear) begin
            r_peak <= ready ? w_mag : 11'd0;
        end else if (ready && (w_mag > r_peak)) begin
            r_peak <= w_mag;
        end
    end

    assign peak_level = r_peak;
`endif

endmodule

// File: tb/tb_compression_controller.sv
// Directed bench for compression_controller with ATTACK=4, HOLD=8, RELEASE=4.
module tb_compression_controller;

    logic               clock;
    logic               reset;
    logic               ready;
    logic signed [11:0] incoming_sample;
    logic               manual_en;
    logic        [1:0]  manual_amount;
    logic        [1:0]  compression_amount;
    logic               amount_changed;
    logic        [1:0]  state_out;
`ifdef COMP_CTRL_PEAK_METER_EN
    logic               peak_clear;
    logic        [10:0] peak_level;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    compression_controller #(
        .ATTACK_SAMPLES (4),
        .HOLD_SAMPLES   (8),
        .RELEASE_SAMPLES(4)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .ready             (ready),
        .incoming_sample   (incoming_sample),
        .manual_en         (manual_en),
        .manual_amount     (manual_amount),
`ifdef COMP_CTRL_PEAK_METER_EN
        .peak_clear        (peak_clear),
        .peak_level        (peak_level),
`endif
        .compression_amount(compression_amount),
        .amount_changed    (amount_changed),
        .state_out         (state_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One ready strobe; returns at the negedge just after the sampling edge.
    task automatic send(input logic signed [11:0] s);
        @(negedge clock);
        ready = 1'b1;
        incoming_sample = s;
        @(negedge clock);
        ready = 1'b0;
        incoming_sample = 12'sd0;
    endtask

    task automatic check_out(input string tag, input logic [1:0] amt, input logic chg,
                             input logic [1:0] st);
        chk({tag, ".amount"}, 32'(compression_amount), 32'(amt));
        chk({tag, ".changed"}, 32'(amount_changed), 32'(chg));
        chk({tag, ".state"}, 32'(state_out), 32'(st));
    endtask

    initial begin
        reset = 1'b0;
        ready = 1'b0;
        incoming_sample = 12'sd0;
        manual_en = 1'b0;
        manual_amount = 2'd0;
`ifdef COMP_CTRL_PEAK_METER_EN
        peak_clear = 1'b0;
`endif
        #1;
        check_out("reset", 2'd0, 1'b0, 2'd0);
        @(negedge clock);
        reset = 1'b1;

        // 600 -> target 1; four consecutive readys raise the amount.
        send(12'sd600);
        send(12'sd600);
        send(12'sd600);
        check_out("atk600_3", 2'd0, 1'b0, 2'd1);
        send(12'sd600);
        check_out("atk600_4", 2'd1, 1'b1, 2'd2);
        @(negedge clock);
        @(negedge clock);
        check_out("frozen", 2'd1, 1'b0, 2'd2);

        // Enter ATTACK at amt=1, then async reset with no clock edge.
        send(12'sd1100);
        check_out("atk_mid", 2'd1, 1'b0, 2'd1);
        #2;
        reset = 1'b0;
        #1;
        check_out("async_rst", 2'd0, 1'b0, 2'd0);
        #1;
        reset = 1'b1;

        // Broken run: 3 x 1600 then 100 restarts the count.
        send(12'sd1600);
        send(12'sd1600);
        send(12'sd1600);
        check_out("run1_3", 2'd0, 1'b0, 2'd1);
        send(12'sd100);
        check_out("break", 2'd0, 1'b0, 2'd2);
        send(12'sd1600);
        send(12'sd1600);
        send(12'sd1600);
        check_out("run2_3", 2'd0, 1'b0, 2'd1);
        send(12'sd1600);
        check_out("run2_4", 2'd1, 1'b1, 2'd2);
        for (int i = 0; i < 4; i++) send(12'sd1600);
        check_out("amt2", 2'd2, 1'b1, 2'd2);

        // Hold 8 readys, then release one step per 4 readys.
        for (int i = 0; i < 7; i++) send(12'sd0);
        check_out("hold7", 2'd2, 1'b0, 2'd2);
        send(12'sd0);
        check_out("hold8", 2'd2, 1'b0, 2'd3);
        for (int i = 0; i < 3; i++) send(12'sd0);
        check_out("rel3", 2'd2, 1'b0, 2'd3);
        send(12'sd0);
        check_out("rel4", 2'd1, 1'b1, 2'd3);
        for (int i = 0; i < 4; i++) send(12'sd0);
        check_out("rel8", 2'd0, 1'b1, 2'd0);

        // -2048 saturates to 2047 (target 3).
        send(-12'sd2048);
        check_out("neg_max1", 2'd0, 1'b0, 2'd1);
        for (int i = 0; i < 3; i++) send(-12'sd2048);
        check_out("neg_max4", 2'd1, 1'b1, 2'd2);

        // Manual override and exit, with no ready strobes.
        @(negedge clock);
        manual_en = 1'b1;
        manual_amount = 2'd3;
        @(negedge clock);
        check_out("man_on", 2'd3, 1'b1, 2'd0);
        @(negedge clock);
        check_out("man_hold", 2'd3, 1'b0, 2'd0);
        manual_en = 1'b0;
        @(negedge clock);
        check_out("man_off", 2'd0, 1'b1, 2'd0);
        @(negedge clock);
        check_out("man_after", 2'd0, 1'b0, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
